// File: rtl/vm2_bctl.sv
// Bus buffer controller for a VM2-style processor: steers the high/low data
// buffer enables and direction from the CPU strobes, with dead time and reply timeout.
module vm2_bctl #(
    parameter int DEAD = 2,
    parameter int TOUT = 64
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       nSYNC,
    input  logic       nDIN,
    input  logic       nDOUT,
    input  logic       nIAKO,
    input  logic       nWTBT,
    input  logic       MA0,
    input  logic       nMRPLY,
    output logic       nBHE,
    output logic       nBLE,
    output logic       nMDIR,
    output logic       BERR,
    output logic       BUSY,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADR, S_TIN, S_DATA, S_HOLD, S_TOUTB, S_FIN
    } state_t;

    localparam logic [3:0] DEAD_LAST = 4'(DEAD - 1);
    localparam logic [9:0] TOUT_LAST = 10'(TOUT - 1);

    // Strobe synchronizers; the SYNC chain resets to "asserted" so a SYNC held
    // through reset release is not mistaken for a fresh rising edge.
    logic [1:0] sync_q, din_q, dout_q, iako_q, rply_q, a0p_q, wtbt_q;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= 2'b00;
            din_q  <= 2'b11;
            dout_q <= 2'b11;
            iako_q <= 2'b11;
            rply_q <= 2'b11;
            a0p_q  <= 2'b00;
            wtbt_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], nSYNC};
            din_q  <= {din_q[0], nDIN};
            dout_q <= {dout_q[0], nDOUT};
            iako_q <= {iako_q[0], nIAKO};
            rply_q <= {rply_q[0], nMRPLY};
            a0p_q  <= {a0p_q[0], MA0};
            wtbt_q <= {wtbt_q[0], nWTBT};
        end
    end

    logic s_sync, s_din, s_dout, s_iako, s_rply;
    assign s_sync = ~sync_q[1];
    assign s_din  = ~din_q[1];
    assign s_dout = ~dout_q[1];
    assign s_iako = ~iako_q[1];
    assign s_rply = ~rply_q[1];

    state_t     state_q, state_d;
    logic [3:0] dead_q, dead_d;
    logic [9:0] tout_q, tout_d;
    logic       a0_q, a0_d, byte_q, byte_d, rd_q, rd_d;
    logic       sync_prev_q;
    logic       nbhe_q, nbhe_d, nble_q, nble_d, nmdir_q, nmdir_d;
    logic       berr_q, berr_d, busy_q, busy_d;
    logic       dead_done, strobes_idle;

    assign dead_done    = (dead_q >= DEAD_LAST);
    assign strobes_idle = !s_din && !s_iako && !s_dout;

    always_comb begin
        state_d = state_q;
        berr_d  = 1'b0;
        a0_d    = a0_q;
        byte_d  = byte_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (s_sync && !sync_prev_q) begin
                    state_d = S_ADR;
                    a0_d    = a0p_q[1];
                    byte_d  = ~wtbt_q[1];
                end
            end
            S_ADR: begin
                if (!s_sync) begin
                    state_d = S_FIN;
                end else if (s_din || s_iako) begin
                    state_d = S_TIN;
                    rd_d    = 1'b1;
                end else if (s_dout) begin
                    state_d = S_DATA;
                    rd_d    = 1'b0;
                end
            end
            S_TIN: begin
                if (!s_sync)        state_d = S_FIN;
                else if (dead_done) state_d = S_DATA;
            end
            S_DATA: begin
                if (!s_sync) begin
                    state_d = S_FIN;
                end else if (s_rply) begin
                    state_d = S_HOLD;
                end else if (tout_q >= TOUT_LAST) begin
                    state_d = S_FIN;
                    berr_d  = 1'b1;
                end
            end
            S_HOLD: begin
                if (!s_sync)           state_d = S_FIN;
                else if (strobes_idle) state_d = S_TOUTB;
            end
            S_TOUTB: begin
                if (!s_sync)        state_d = S_FIN;
                else if (dead_done) state_d = S_ADR;
            end
            S_FIN: begin
                if (dead_done && !s_sync) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Both counters restart on every state change; the timeout only advances in DATA.
    always_comb begin
        dead_d = dead_q;
        tout_d = tout_q;
        if (state_d != state_q) begin
            dead_d = 4'd0;
            tout_d = 10'd0;
        end else begin
            if (dead_q != 4'hF) dead_d = dead_q + 4'd1;
            if (state_q == S_DATA && tout_q != 10'h3FF) tout_d = tout_q + 10'd1;
        end
    end

    // Outputs are decoded from the next state so they register together with it.
    always_comb begin
        nbhe_d  = 1'b1;
        nble_d  = 1'b1;
        nmdir_d = 1'b0;
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_ADR: begin
                nbhe_d = 1'b0;
                nble_d = 1'b0;
            end
            S_TIN: nmdir_d = 1'b1;
            S_DATA, S_HOLD: begin
                if (rd_d) begin
                    nbhe_d  = 1'b0;
                    nble_d  = 1'b0;
                    nmdir_d = 1'b1;
                end else if (!byte_d) begin
                    nbhe_d = 1'b0;
                    nble_d = 1'b0;
                end else begin
                    nbhe_d = ~a0_d;
                    nble_d = a0_d;
                end
            end
            // Direction is held until the dead time in FIN has run out.
            S_FIN: nmdir_d = (state_q == S_FIN && dead_done) ? 1'b0 : nmdir_q;
            default: ;
        endcase
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            dead_q      <= 4'd0;
            tout_q      <= 10'd0;
            a0_q        <= 1'b0;
            byte_q      <= 1'b0;
            rd_q        <= 1'b0;
            sync_prev_q <= 1'b1;
            nbhe_q      <= 1'b1;
            nble_q      <= 1'b1;
            nmdir_q     <= 1'b0;
            berr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dead_q      <= dead_d;
            tout_q      <= tout_d;
            a0_q        <= a0_d;
            byte_q      <= byte_d;
            rd_q        <= rd_d;
            sync_prev_q <= s_sync;
            nbhe_q      <= nbhe_d;
            nble_q      <= nble_d;
            nmdir_q     <= nmdir_d;
            berr_q      <= berr_d;
            busy_q      <= busy_d;
        end
    end

    assign nBHE        = nbhe_q;
    assign nBLE        = nble_q;
    assign nMDIR       = nmdir_q;
    assign BERR        = berr_q;
    assign BUSY        = busy_q;
    assign dbg_state_o = state_q;

endmodule
